// File: rtl/counter4_sched_if.sv
// Requester-side bus of the counter4 scheduler: requests, job parameters and completion report.
// The requester side drives the master modport. The scheduler uses the slave modport.
interface counter4_sched_if #(
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             by2_0;
    logic             by2_1;
    logic [1:0]       grant;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             aborted;
    logic [LEN_W-1:0] steps_done;
    logic [3:0]       result;

    modport master (
        output req, len0, len1, by2_0, by2_1,
        input  grant, busy, done, done_id, aborted, steps_done, result
    );

    modport slave (
        input  req, len0, len1, by2_0, by2_1,
        output grant, busy, done, done_id, aborted, steps_done, result
    );
endinterface

// File: rtl/counter4_sched.sv
// Round-robin scheduler that lends one shared 4-bit up-counter to two requesters,
// driving its nE/cntby2 for a requested number of enable cycles and reporting the final count.
module counter4_sched #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             nReset,
    counter4_sched_if.slave  bus,
    input  logic [3:0]       count_in,
    output logic             cnt_nE,
    output logic             cnt_by2
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state, state_nx;
    logic             sel, sel_nx;        // requester currently granted
    logic             ptr, ptr_nx;        // requester favoured at the next tie
    logic             mode, mode_nx;      // latched step-by-2 request
    logic             abort_r, abort_nx;
    logic [LEN_W-1:0] remaining, remaining_nx;
    logic [LEN_W-1:0] steps, steps_nx;

    logic [LEN_W-1:0] len_sel;
    logic             by2_sel;
    logic             pick;

    assign len_sel = sel ? bus.len1  : bus.len0;
    assign by2_sel = sel ? bus.by2_1 : bus.by2_0;
    assign pick    = bus.req[ptr] ? ptr : ~ptr;

    // NOTE: every next-state variable takes its current value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        ptr_nx       = ptr;
        mode_nx      = mode;
        abort_nx     = abort_r;
        remaining_nx = remaining;
        steps_nx     = steps;
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    sel_nx   = pick;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                remaining_nx = len_sel;
                steps_nx     = '0;
                mode_nx      = by2_sel;
                abort_nx     = 1'b0;
                state_nx     = (len_sel == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // The counter steps on this edge whether the run finishes or is cut short.
                remaining_nx = remaining - LEN_W'(1);
                steps_nx     = steps + LEN_W'(1);
                if (!bus.req[sel]) begin
                    abort_nx = 1'b1;
                    state_nx = S_DONE;
                end else if (remaining == LEN_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                ptr_nx   = ~sel;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            ptr       <= 1'b0;
            mode      <= 1'b0;
            abort_r   <= 1'b0;
            remaining <= '0;
            steps     <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            ptr       <= ptr_nx;
            mode      <= mode_nx;
            abort_r   <= abort_nx;
            remaining <= remaining_nx;
            steps     <= steps_nx;
        end
    end

    // Moore decodes only; report fields read as zero whenever done is low.
    always_comb begin
        bus.grant      = (state != S_IDLE) ? (sel ? 2'b10 : 2'b01) : 2'b00;
        bus.busy       = (state != S_IDLE);
        bus.done       = (state == S_DONE);
        bus.done_id    = (state == S_DONE) & sel;
        bus.aborted    = (state == S_DONE) & abort_r;
        bus.steps_done = (state == S_DONE) ? steps : '0;
        bus.result     = (state == S_DONE) ? count_in : 4'd0;
        cnt_nE         = (state != S_RUN);
        cnt_by2        = (state == S_RUN) & mode;
    end

    a_grant_onehot : assert property (@(posedge clk) disable iff (!nReset) $onehot0(bus.grant));
    a_run_nonzero  : assert property (@(posedge clk) disable iff (!nReset) (state == S_RUN) |-> (remaining != '0));

endmodule

// File: tb/tb_counter4_sched.sv
// Bench for counter4_sched: a behavioural 4-bit counter feeds count_in, and a job-level model
// (round-robin pointer plus mod-16 arithmetic) predicts grant order, timing and results.
module tb_counter4_sched;
    localparam int LEN_W = 4;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic [3:0] count;
    logic       cnt_nE, cnt_by2;

    always #5 clk = ~clk;

    counter4_sched_if #(.LEN_W(LEN_W)) sif ();

    counter4_sched #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .bus      (sif),
        .count_in (count),
        .cnt_nE   (cnt_nE),
        .cnt_by2  (cnt_by2)
    );

    // The shared counter the scheduler drives; it shares nReset with the DUT.
    always @(posedge clk or negedge nReset) begin
        if (!nReset)      count <= 4'd0;
        else if (!cnt_nE) count <= count + (cnt_by2 ? 4'd2 : 4'd1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count;
    bit model_ptr;

    function automatic int winner(input logic [1:0] r);
        if (r[model_ptr]) return int'(model_ptr);
        return int'(!model_ptr);
    endfunction

    task automatic drive_req(input int id, input int len, input bit by2);
        if (id == 0) begin sif.len0 = LEN_W'(len); sif.by2_0 = by2; end
        else         begin sif.len1 = LEN_W'(len); sif.by2_1 = by2; end
        sif.req[id] = 1'b1;
    endtask

    // Caller is at a negedge with the DUT in IDLE or about to load this requester's job.
    task automatic serve_job(input string tag, input int id, input int len, input bit by2, input int abort_at);
        int         steps_e;
        int         t_done = -1;
        int         ne_low = 0;
        int         by2_hi = 0;
        int         g_bad  = 0;
        logic [1:0] g_first = 2'b00;
        logic [1:0] g_exp;
        logic       d_id = 1'b0, d_ab = 1'b0;
        logic [3:0] d_steps = 4'd0, d_res = 4'd0;

        steps_e   = (abort_at > 0) ? abort_at : len;
        g_exp     = (id == 1) ? 2'b10 : 2'b01;
        exp_count = (exp_count + steps_e * (by2 ? 2 : 1)) % 16;

        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t == 1) g_first = sif.grant;
            if (t == 2) begin
                // Parameters moved after LOAD must not affect the running job.
                if (id == 0) begin sif.len0 = LEN_W'($urandom); sif.by2_0 = ~by2; end
                else         begin sif.len1 = LEN_W'($urandom); sif.by2_1 = ~by2; end
            end
            if (sif.grant !== g_exp) g_bad++;
            if (cnt_nE === 1'b0)  ne_low++;
            if (cnt_by2 === 1'b1) by2_hi++;
            if (abort_at > 0 && ne_low == abort_at) sif.req[id] = 1'b0;
            if (sif.done === 1'b1) begin
                t_done  = t;
                d_id    = sif.done_id;
                d_ab    = sif.aborted;
                d_steps = sif.steps_done;
                d_res   = sif.result;
                break;
            end
        end
        sif.req[id] = 1'b0;
        model_ptr   = (id == 0);

        n_cmp++; if (g_first !== g_exp) begin n_bad++; $display("FAIL %s grant_at_load: got %b want %b", tag, g_first, g_exp); end
        n_cmp++; if (g_bad !== 0) begin n_bad++; $display("FAIL %s grant_held: %0d bad cycles, want 0", tag, g_bad); end
        n_cmp++; if (t_done !== steps_e + 2) begin n_bad++; $display("FAIL %s done_latency: got %0d want %0d", tag, t_done, steps_e + 2); end
        n_cmp++; if (ne_low !== steps_e) begin n_bad++; $display("FAIL %s nE_low_cycles: got %0d want %0d", tag, ne_low, steps_e); end
        n_cmp++; if (by2_hi !== (by2 ? steps_e : 0)) begin n_bad++; $display("FAIL %s by2_cycles: got %0d want %0d", tag, by2_hi, by2 ? steps_e : 0); end
        n_cmp++; if (d_id !== id[0]) begin n_bad++; $display("FAIL %s done_id: got %b want %0d", tag, d_id, id); end
        n_cmp++; if (d_ab !== (abort_at > 0)) begin n_bad++; $display("FAIL %s aborted: got %b want %b", tag, d_ab, abort_at > 0); end
        n_cmp++; if (d_steps !== LEN_W'(steps_e)) begin n_bad++; $display("FAIL %s steps_done: got %0d want %0d", tag, d_steps, steps_e); end
        n_cmp++; if (d_res !== 4'(exp_count)) begin n_bad++; $display("FAIL %s result: got %0d want %0d", tag, d_res, exp_count); end

        @(negedge clk);
        n_cmp++;
        if ({sif.done, sif.busy, sif.grant, sif.result} !== 9'd0) begin
            n_bad++;
            $display("FAIL %s after_done: done=%b busy=%b grant=%b result=%0d, want all 0",
                     tag, sif.done, sif.busy, sif.grant, sif.result);
        end
    endtask

    task automatic test_reset();
        sif.req = 2'b00;
        nReset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({sif.grant, sif.busy, cnt_nE, cnt_by2, sif.done, sif.done_id, sif.aborted, sif.steps_done, sif.result}
            !== {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: grant=%b busy=%b nE=%b by2=%b done=%b id=%b ab=%b steps=%0d res=%0d",
                     sif.grant, sif.busy, cnt_nE, cnt_by2, sif.done, sif.done_id, sif.aborted, sif.steps_done, sif.result);
        end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        nReset    = 1'b1;
        exp_count = 0;
        model_ptr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        drive_req(0, 3, 1'b0); serve_job("basic", 0, 3, 1'b0, 0);
        drive_req(1, 4, 1'b1); serve_job("by2", 1, 4, 1'b1, 0);
        drive_req(0, 5, 1'b1); serve_job("wrap", 0, 5, 1'b1, 0);
    endtask

    task automatic test_simultaneous();
        int w;
        test_reset();
        drive_req(0, 2, 1'b0); drive_req(1, 2, 1'b0);
        w = winner(2'b11);
        serve_job("simul_first", w, 2, 1'b0, 0);
        serve_job("simul_second", 1 - w, 2, 1'b0, 0);
        // One more job from requester 0 leaves the pointer favouring requester 1.
        drive_req(0, 1, 1'b0); serve_job("simul_single", 0, 1, 1'b0, 0);
        drive_req(0, 2, 1'b0); drive_req(1, 2, 1'b0);
        w = winner(2'b11);
        serve_job("simul_flip_first", w, 2, 1'b0, 0);
        serve_job("simul_flip_second", 1 - w, 2, 1'b0, 0);
    endtask

    task automatic test_abort_and_zero();
        drive_req(0, 6, 1'b0); serve_job("abort", 0, 6, 1'b0, 3);
        drive_req(1, 0, 1'b1); serve_job("zero_len", 1, 0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_run();
        int  ne_low = 0;
        bit  seen_done = 1'b0;
        drive_req(0, 10, 1'b0);
        for (int t = 0; t < 20 && ne_low < 4; t++) begin
            @(negedge clk);
            if (cnt_nE === 1'b0) ne_low++;
        end
        n_cmp++; if (ne_low !== 4) begin n_bad++; $display("FAIL midrun_reach: got %0d RUN cycles want 4", ne_low); end
        #1 nReset = 1'b0;
        #1;
        n_cmp++;
        if ({sif.grant, sif.busy, cnt_nE, sif.done} !== {2'b00, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: grant=%b busy=%b nE=%b done=%b want 00 0 1 0",
                     sif.grant, sif.busy, cnt_nE, sif.done);
        end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL midrun_reset_count: got %0d want 0", count); end
        sif.req = 2'b00;
        #1 nReset = 1'b1;
        exp_count = 0;
        model_ptr = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (sif.done === 1'b1 || cnt_nE !== 1'b1) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done) begin n_bad++; $display("FAIL midrun_quiet: got activity after reset want none"); end
        drive_req(0, 7, 1'b1); serve_job("after_reset", 0, 7, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int         pat;
            int         la, lb, ab, w;
            bit         ba, bb;
            pat = $urandom_range(1, 3);
            la  = $urandom_range(0, 15);
            lb  = $urandom_range(0, 15);
            ba  = 1'($urandom);
            bb  = 1'($urandom);
            if (pat == 3) begin
                drive_req(0, la, ba); drive_req(1, lb, bb);
                w = winner(2'b11);
                serve_job("rand_pair_a", w, (w == 0) ? la : lb, (w == 0) ? ba : bb, 0);
                serve_job("rand_pair_b", 1 - w, (w == 0) ? lb : la, (w == 0) ? bb : ba, 0);
            end else begin
                w  = pat - 1;
                ab = (la >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, la - 1) : 0;
                drive_req(w, la, ba);
                serve_job("rand_single", w, la, ba, ab);
            end
        end
    endtask

    initial begin
        sif.req   = 2'b00;
        sif.len0  = '0;
        sif.len1  = '0;
        sif.by2_0 = 1'b0;
        sif.by2_1 = 1'b0;
        test_reset();
        test_directed();
        test_simultaneous();
        test_abort_and_zero();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
